// File: rtl/aes_pkg.sv
// Shared AES constants and byte-level helpers used by the forward and inverse datapaths.
// Bytes are MSB-first: byte 1 of a 128-bit word is bits [127:120].
package aes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_KEYEXP = 2'd1,
    ST_ROUND  = 2'd2,
    ST_DONE   = 2'd3
  } aes_state_e;

  localparam logic [3:0] LAST_RND = 4'd10;

  // Row 0 of each table sits in the MSBs, so entry b lives at packed index ~b.
  localparam logic [255:0][7:0] SBOX_T = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [255:0][7:0] INV_SBOX_T = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    logic [7:0] v;
    case (idx)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h40;
      4'd8:    v = 8'h80;
      4'd9:    v = 8'h1b;
      4'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_T[~b];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX_T[~b];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul09(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ b;
  endfunction

  function automatic logic [7:0] mul0b(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] mul0d(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction

  function automatic logic [7:0] mul0e(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction

endpackage

// File: rtl/inv_byte_transform.sv
// Combinational InvShiftRows followed by InvSubBytes on a column-major 128-bit state.
module inv_byte_transform
  import aes_pkg::*;
(
  input  logic [127:0] i_state,
  output logic [127:0] o_state
);

  // State byte s[r][c] is byte index 4c+r; row r rotates right by r columns.
  always_comb begin
    o_state = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o_state[127 - 8*(4*c + r) -: 8] =
          inv_sbox(i_state[127 - 8*(4*((c - r + 4) % 4) + r) -: 8]);
      end
    end
  end

endmodule

// File: rtl/aes_inv_cipher.sv
// Iterative AES-128 decryption: forward key expansion to rk10, then one inverse round per clock.
// Optional rk10 cache for a repeated key is enabled with `define AES_INV_KEY_CACHE_EN.
module aes_inv_cipher
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] aesIn,
  input  logic [127:0] keyIn,
  output logic         busy,
  output logic         ready,
  output logic [127:0] aesOut,
  output aes_state_e   o_dbg_state
);

  // Handshake: start is sampled only in IDLE/DONE and accepted on that edge; ready is a
  // level that stays high, with aesOut stable, until the next accepted start.

  aes_state_e   r_state, w_state_nxt;
  logic [3:0]   r_rnd, w_rnd_nxt;
  logic [127:0] r_st, w_st_nxt;
  logic [127:0] r_key, w_key_nxt;
  logic [127:0] r_out, w_out_nxt;

  logic [127:0] w_key_fwd;
  logic [127:0] w_rk;
  logic [127:0] w_bt;
  logic [127:0] w_ark;
  logic [127:0] w_round_out;

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [127:0] key_fwd(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] n0, n1, n2, n3;
    n0 = k[127:96] ^ sub_word(rot_word(k[31:0])) ^ {rc, 24'h0};
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0]  ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // Undo one schedule step: recover the previous words from the later ones, w3 first.
  function automatic logic [127:0] key_inv(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] n0, n1, n2, n3;
    n3 = k[31:0]  ^ k[63:32];
    n2 = k[63:32] ^ k[95:64];
    n1 = k[95:64] ^ k[127:96];
    n0 = k[127:96] ^ sub_word(rot_word(n3)) ^ {rc, 24'h0};
    return {n0, n1, n2, n3};
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = w;
    return {mul0e(a0) ^ mul0b(a1) ^ mul0d(a2) ^ mul09(a3),
            mul09(a0) ^ mul0e(a1) ^ mul0b(a2) ^ mul0d(a3),
            mul0d(a0) ^ mul09(a1) ^ mul0e(a2) ^ mul0b(a3),
            mul0b(a0) ^ mul0d(a1) ^ mul09(a2) ^ mul0e(a3)};
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      r[127 - 32*c -: 32] = inv_mix_col(s[127 - 32*c -: 32]);
    end
    return r;
  endfunction

  inv_byte_transform u_inv_bt (
    .i_state (r_st),
    .o_state (w_bt)
  );

  assign w_key_fwd   = key_fwd(r_key, rcon(r_rnd));
  assign w_rk        = key_inv(r_key, rcon(r_rnd + 4'd1));
  assign w_ark       = w_bt ^ w_rk;
  assign w_round_out = (r_rnd == 4'd0) ? w_ark : inv_mix(w_ark);
  assign aesOut      = r_out;
  assign o_dbg_state = r_state;

`ifdef AES_INV_KEY_CACHE_EN
  logic [127:0] r_cache_key;
  logic [127:0] r_cache_rk;
  logic         r_cache_vld;
  logic         w_cache_hit;
  logic         w_idle_start;
  logic         w_fill;

  assign w_idle_start = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && start;
  assign w_cache_hit  = r_cache_vld && (keyIn == r_cache_key);
  assign w_fill       = (r_state == ST_KEYEXP) && (r_rnd == LAST_RND);

  // The key is latched at acceptance but only marked valid once its rk10 exists.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cache_key <= '0;
      r_cache_rk  <= '0;
      r_cache_vld <= 1'b0;
    end else begin
      if (w_idle_start && !w_cache_hit) begin
        r_cache_key <= keyIn;
        r_cache_vld <= 1'b0;
      end
      if (w_fill) begin
        r_cache_rk  <= w_key_fwd;
        r_cache_vld <= 1'b1;
      end
    end
  end
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_rnd_nxt   = r_rnd;
    w_st_nxt    = r_st;
    w_key_nxt   = r_key;
    w_out_nxt   = r_out;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_st_nxt    = aesIn;
          w_key_nxt   = keyIn;
          w_rnd_nxt   = 4'd1;
          w_state_nxt = ST_KEYEXP;
`ifdef AES_INV_KEY_CACHE_EN
          if (w_cache_hit) begin
            w_st_nxt    = aesIn ^ r_cache_rk;
            w_key_nxt   = r_cache_rk;
            w_rnd_nxt   = 4'd9;
            w_state_nxt = ST_ROUND;
          end
`endif
        end
      end
      ST_KEYEXP: begin
        w_key_nxt = w_key_fwd;
        if (r_rnd == LAST_RND) begin
          w_st_nxt    = r_st ^ w_key_fwd;
          w_rnd_nxt   = 4'd9;
          w_state_nxt = ST_ROUND;
        end else begin
          w_rnd_nxt = r_rnd + 4'd1;
        end
      end
      ST_ROUND: begin
        w_key_nxt = w_rk;
        w_st_nxt  = w_round_out;
        if (r_rnd == 4'd0) begin
          w_out_nxt   = w_round_out;
          w_state_nxt = ST_DONE;
        end else begin
          w_rnd_nxt = r_rnd - 4'd1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    busy  = (r_state == ST_KEYEXP) || (r_state == ST_ROUND);
    ready = (r_state == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_rnd   <= 4'd0;
      r_st    <= '0;
      r_key   <= '0;
      r_out   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_rnd   <= w_rnd_nxt;
      r_st    <= w_st_nxt;
      r_key   <= w_key_nxt;
      r_out   <= w_out_nxt;
    end
  end

endmodule

// File: tb/tb_aes_inv_cipher.sv
// Bench for aes_inv_cipher: FIPS-197 vectors, control corner cases and random blocks
// against a table-free AES decryption model; cache latency is modelled when AES_INV_KEY_CACHE_EN is set.
module tb_aes_inv_cipher;
  import aes_pkg::*;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam int           WAIT_MAX = 40;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [127:0] aes_in = '0;
  logic [127:0] key_in = '0;
  logic         busy;
  logic         ready;
  logic [127:0] aes_out;
  aes_state_e   dbg_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  aes_inv_cipher dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .aesIn       (aes_in),
    .keyIn       (key_in),
    .busy        (busy),
    .ready       (ready),
    .aesOut      (aes_out),
    .o_dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [127:0] exp_q[$];
  int           lat_q[$];
  int           checks = 0;
  int           errors = 0;
  int           start_cyc = 0;
  bit           pending = 0;
  bit           prev_ready = 0;
  logic [127:0] mon_e;
  int           mon_l;
  logic [127:0] m_cache_key = '0;
  bit           m_cache_vld = 0;
  bit           m_fill = 0;
  logic [7:0]   sb [256];
  logic [7:0]   isb[256];

  task automatic chk128(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model (GF arithmetic, no stored tables) ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  task automatic build_tables();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] v, inv, s;
      v = x[7:0];
      inv = 8'h00;
      if (v != 8'h00) begin
        inv = 8'h01;
        for (int k = 0; k < 254; k++) inv = gmul(inv, v);
      end
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sb[x] = s;
      isb[s] = v;
    end
  endtask

  function automatic logic [127:0] ref_decrypt(input logic [127:0] ct, input logic [127:0] key);
    logic [31:0]  w[44];
    logic [7:0]   s[16];
    logic [7:0]   t[16];
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [31:0]  tmp;
    logic [127:0] res;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = ct[127 - 8*i -: 8] ^ w[40 + i/4][31 - 8*(i%4) -: 8];
    for (int rd = 9; rd >= 0; rd--) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          t[4*c + r] = isb[s[4*((c - r + 4) % 4) + r]];
      for (int i = 0; i < 16; i++) s[i] = t[i] ^ w[4*rd + i/4][31 - 8*(i%4) -: 8];
      if (rd > 0) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
          s[4*c+1] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
          s[4*c+2] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
          s[4*c+3] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
        end
      end
    end
    for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = s[i];
    return res;
  endfunction

  // Expected cycles from the accepting edge to ready for a block started with this key.
  task automatic model_start(input logic [127:0] key, output int lat);
`ifdef AES_INV_KEY_CACHE_EN
    if (m_cache_vld && key == m_cache_key) begin
      lat = 10;
      m_fill = 0;
    end else begin
      lat = 20;
      m_cache_key = key;
      m_cache_vld = 0;
      m_fill = 1;
    end
`else
    lat = 20;
    m_fill = 0;
`endif
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic start_op(input logic [127:0] ct, input logic [127:0] key, input logic [127:0] exp);
    int lat;
    @(negedge clk);
    model_start(key, lat);
    start  = 1'b1;
    aes_in = ct;
    key_in = key;
    exp_q.push_back(exp);
    lat_q.push_back(lat);
    @(posedge clk);
    #1;
    start_cyc = cyc;
    pending   = 1;
    start     = 1'b0;
    aes_in    = rand128();
    key_in    = rand128();
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (pending && n < WAIT_MAX) begin
      @(negedge clk);
      #2;
      n++;
    end
    if (pending) begin
      checks++;
      errors++;
      $display("FAIL timeout: ready still low after %0d cycles, required within %0d", n, WAIT_MAX);
      pending = 0;
      exp_q.delete();
      lat_q.delete();
    end
  endtask

  task automatic hold_check(input logic [127:0] exp, input int n);
    repeat (n) begin
      @(negedge clk);
      #2;
      chk1("ready_hold", ready, 1'b1);
      chk128("out_hold", aes_out, exp);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (ready && !prev_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ready: got ready=1 with out=%h, required no result pending", aes_out);
        end else begin
          mon_e = exp_q.pop_front();
          mon_l = lat_q.pop_front();
          chk128("plaintext", aes_out, mon_e);
          chk_int("latency", cyc - start_cyc, mon_l);
          chk1("busy_at_ready", busy, 1'b0);
          pending = 0;
          if (m_fill) m_cache_vld = 1;
          m_fill = 0;
        end
      end else if (pending) begin
        chk1("busy_running", busy, 1'b1);
        chk1("ready_running", ready, 1'b0);
      end
    end
    prev_ready = ready;
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [127:0] ct, key, prev_key;
    build_tables();

    repeat (3) @(negedge clk);
    chk1("reset_ready", ready, 1'b0);
    chk1("reset_busy", busy, 1'b0);
    chk128("reset_out", aes_out, 128'h0);
    rst_n = 1'b1;

    // FIPS-197 C.1, then hold in DONE.
    start_op(C1_CT, C1_KEY, C1_PT);
    wait_done();
    hold_check(C1_PT, 3);

    // A start pulse mid-operation must be ignored.
    start_op(C1_CT, C1_KEY, C1_PT);
    repeat (6) @(negedge clk);
    start  = 1'b1;
    aes_in = rand128();
    key_in = rand128();
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done();
    hold_check(C1_PT, 3);

    // Back-to-back restart from DONE with FIPS-197 B.
    start_op(B_CT, B_KEY, B_PT);
    chk1("ready_drop", ready, 1'b0);
    wait_done();

    // Repeated key, new key, then the first key again.
    start_op(C1_CT, C1_KEY, C1_PT);
    wait_done();
    ct = rand128();
    start_op(ct, C1_KEY, ref_decrypt(ct, C1_KEY));
    wait_done();
    start_op(B_CT, B_KEY, B_PT);
    wait_done();
    start_op(C1_CT, C1_KEY, C1_PT);
    wait_done();

    // Reset mid-operation aborts cleanly; the next block still completes.
    start_op(B_CT, B_KEY, B_PT);
    repeat (11) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk1("abort_ready", ready, 1'b0);
    chk1("abort_busy", busy, 1'b0);
    chk128("abort_out", aes_out, 128'h0);
    pending = 0;
    exp_q.delete();
    lat_q.delete();
    m_cache_vld = 0;
    m_fill = 0;
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    start_op(C1_CT, C1_KEY, C1_PT);
    wait_done();

    // Random blocks, sometimes reusing the previous key.
    prev_key = C1_KEY;
    for (int i = 0; i < 10; i++) begin
      key = ($urandom_range(0, 2) == 0) ? prev_key : rand128();
      ct  = rand128();
      start_op(ct, key, ref_decrypt(ct, key));
      wait_done();
      prev_key = key;
    end

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL leftover: %0d results never appeared, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
